mul_div_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits directly downstream of the instruction decoder. It consumes R-type SPECIAL instructions: opcode 000000 with funct MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI or MFLO.
- It stalls the core while an operation is in flight and returns HI/LO on MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// MULT/DIV run 32 iteration cycles plus one fixup cycle; MT*/MF* are serviced in IDLE.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_valid_i,
  input  logic [5:0]      md_funct_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0] rt_data_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] x);
    return ~x + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Magnitudes are kept unsigned, so |0x80000000| = 0x80000000 without overflow.
  function automatic logic [XLEN-1:0] abs_x(input logic [XLEN-1:0] x, input logic sgn);
    return sgn ? neg_x(x) : x;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  opnd_b;
  logic             op_div;
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;

  logic             is_mdu;
  logic             is_start;
  logic             start_signed;
  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_shift;
  logic             div_ge;
  logic [XLEN-1:0]  step_hi;
  logic [XLEN-1:0]  step_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]  fix_hi;
  logic [XLEN-1:0]  fix_lo;

  // Funct decode for the eight MDU instructions.
  always_comb begin
    is_mdu   = 1'b0;
    is_start = 1'b0;
    case (md_funct_i)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO: is_mdu = 1'b1;
      F_MULT, F_MULTU, F_DIV, F_DIVU: begin
        is_mdu   = 1'b1;
        is_start = 1'b1;
      end
      default: begin
        is_mdu   = 1'b0;
        is_start = 1'b0;
      end
    endcase
    start_signed = ~md_funct_i[0];
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(XLEN+1){1'b0}});
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_b});
    if (op_div) begin
      step_hi = div_ge ? (div_shift[XLEN-1:0] - opnd_b) : div_shift[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // Sign correction applied in the FIXUP cycle; divide-by-zero values pass through raw.
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (div_zero) begin
      fix_hi = acc_hi;
      fix_lo = acc_lo;
    end else if (op_div) begin
      fix_lo = (op_signed && (sign_a ^ sign_b)) ? neg_x(acc_lo) : acc_lo;
      fix_hi = (op_signed && sign_a) ? neg_x(acc_hi) : acc_hi;
    end else if (op_signed && (sign_a ^ sign_b)) begin
      {fix_hi, fix_lo} = neg_2x(prod);
    end else begin
      {fix_hi, fix_lo} = prod;
    end
  end

  // Control FSM, working accumulator and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= {CNT_W{1'b0}};
      hi        <= ZERO;
      lo        <= ZERO;
      acc_hi    <= ZERO;
      acc_lo    <= ZERO;
      opnd_b    <= ZERO;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_valid_i && is_start) begin
            op_div    <= md_funct_i[1];
            op_signed <= start_signed;
            sign_a    <= start_signed & rs_data_i[XLEN-1];
            sign_b    <= start_signed & rt_data_i[XLEN-1];
            opnd_b    <= abs_x(rt_data_i, start_signed & rt_data_i[XLEN-1]);
            cnt       <= {CNT_W{1'b0}};
            if (md_funct_i[1] && (rt_data_i == ZERO)) begin
              div_zero <= 1'b1;
              acc_hi   <= rs_data_i;
              acc_lo   <= ALL_ONES;
              state    <= S_FIXUP;
            end else begin
              div_zero <= 1'b0;
              acc_hi   <= ZERO;
              acc_lo   <= abs_x(rs_data_i, start_signed & rs_data_i[XLEN-1]);
              state    <= S_ITER;
            end
          end else if (md_valid_i && (md_funct_i == F_MTHI)) begin
            hi <= rs_data_i;
          end else if (md_valid_i && (md_funct_i == F_MTLO)) begin
            lo <= rs_data_i;
          end
        end
        S_ITER: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status decode and the MFHI/MFLO read port.
  always_comb begin
    busy_o  = (state != S_IDLE);
    done_o  = (state == S_FIXUP);
    stall_o = md_valid_i & busy_o & is_mdu;
    if (md_valid_i && !busy_o && (md_funct_i == F_MFHI)) begin
      rd_data_o = hi;
    end else if (md_valid_i && !busy_o && (md_funct_i == F_MFLO)) begin
      rd_data_o = lo;
    end else begin
      rd_data_o = ZERO;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, results, stall, MT*/MF*, reset abort.
module tb_mul_div_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid_i;
  logic [5:0]  md_funct_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic [31:0] rd_data_o;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_valid_i (md_valid_i),
    .md_funct_i (md_funct_i),
    .rs_data_i  (rs_data_i),
    .rt_data_i  (rt_data_i),
    .rd_data_o  (rd_data_o),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    md_valid_i = 1'b0;
    md_funct_i = 6'd0;
    rs_data_i  = 32'd0;
    rt_data_i  = 32'd0;
  endtask

  // Present a start instruction for one cycle; returns at the negedge of busy cycle 1.
  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    md_valid_i = 1'b1;
    md_funct_i = f;
    rs_data_i  = a;
    rt_data_i  = b;
    #1;
    check("accept_no_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    idle_inputs();
  endtask

  // Count busy cycles and the position of the single done pulse, with a bound.
  task automatic wait_result(input string tag, input int exp_n);
    int n = 0;
    int done_at = 0;
    int done_cnt = 0;
    while (busy_o === 1'b1 && n < 200) begin
      n++;
      if (done_o === 1'b1) begin
        done_at = n;
        done_cnt++;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_done_pos"}, 32'(done_at), 32'(exp_n));
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_low_after"}, {31'd0, done_o}, 32'd0);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    md_valid_i = 1'b1;
    md_funct_i = F_MFHI;
    #1;
    check({tag, "_hi"}, rd_data_o, exp_hi);
    md_funct_i = F_MFLO;
    #1;
    check({tag, "_lo"}, rd_data_o, exp_lo);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    int stall_cnt;
    int saw_done;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_rd", rd_data_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    read_hilo("rst", 32'd0, 32'd0);

    start_op(F_MULT, 32'hFFFFFFFD, 32'd5);
    wait_result("mult_neg", 33);
    read_hilo("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);

    start_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result("multu_max", 33);
    read_hilo("multu_max", 32'hFFFFFFFE, 32'h00000001);
    start_op(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result("mult_m1", 33);
    read_hilo("mult_m1", 32'h00000000, 32'h00000001);

    start_op(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_result("div_neg", 33);
    read_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    start_op(F_DIVU, 32'd100, 32'd7);
    wait_result("divu", 33);
    read_hilo("divu", 32'd2, 32'd14);
    start_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_result("div_ovf", 33);
    read_hilo("div_ovf", 32'h00000000, 32'h80000000);

    start_op(F_DIVU, 32'h00001234, 32'd0);
    wait_result("divu_zero", 1);
    read_hilo("divu_zero", 32'h00001234, 32'hFFFFFFFF);
    start_op(F_DIV, 32'hFFFFFF00, 32'd0);
    wait_result("div_zero", 1);
    read_hilo("div_zero", 32'hFFFFFF00, 32'hFFFFFFFF);

    // MFLO presented right behind a MULT must stall through every busy cycle.
    start_op(F_MULT, 32'hFFFFFFFA, 32'd7);
    md_valid_i = 1'b1;
    md_funct_i = F_MFLO;
    stall_cnt = 0;
    for (int i = 0; i < 200 && busy_o === 1'b1; i++) begin
      #1;
      if (stall_o === 1'b1) stall_cnt++;
      @(negedge clk);
    end
    #1;
    check("mflo_stall_cycles", 32'(stall_cnt), 32'd33);
    check("mflo_stall_released", {31'd0, stall_o}, 32'd0);
    check("mflo_after_busy", rd_data_o, 32'hFFFFFFD6);
    idle_inputs();
    @(negedge clk);
    read_hilo("mult_m6x7", 32'hFFFFFFFF, 32'hFFFFFFD6);

    md_valid_i = 1'b1;
    md_funct_i = F_MTHI;
    rs_data_i  = 32'hA5A5A5A5;
    @(negedge clk);
    idle_inputs();
    check("mthi_no_busy", {31'd0, busy_o}, 32'd0);
    read_hilo("mthi", 32'hA5A5A5A5, 32'hFFFFFFD6);
    md_valid_i = 1'b1;
    md_funct_i = F_MTLO;
    rs_data_i  = 32'h0F0F0F0F;
    @(negedge clk);
    idle_inputs();
    read_hilo("mtlo", 32'hA5A5A5A5, 32'h0F0F0F0F);

    // Non-MDU funct with valid, and an MDU funct without valid, are both ignored.
    md_valid_i = 1'b1;
    md_funct_i = 6'b100000;
    rs_data_i  = 32'hDEADBEEF;
    rt_data_i  = 32'd3;
    #1;
    check("nonmdu_rd", rd_data_o, 32'd0);
    @(negedge clk);
    check("nonmdu_busy", {31'd0, busy_o}, 32'd0);
    md_valid_i = 1'b0;
    md_funct_i = F_MTHI;
    @(negedge clk);
    md_funct_i = F_MULT;
    @(negedge clk);
    check("novalid_busy", {31'd0, busy_o}, 32'd0);
    idle_inputs();
    read_hilo("ignored", 32'hA5A5A5A5, 32'h0F0F0F0F);

    // Reset in busy cycle 10 aborts the divide with no done pulse.
    start_op(F_DIVU, 32'd100, 32'd7);
    saw_done = 0;
    for (int i = 1; i < 10; i++) begin
      if (done_o === 1'b1) saw_done++;
      @(negedge clk);
    end
    check("abort_busy_c10", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (done_o === 1'b1 || busy_o === 1'b1) saw_done++;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    start_op(F_MULTU, 32'd6, 32'd7);
    wait_result("multu_6x7", 33);
    read_hilo("multu_6x7", 32'd0, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
